// File: rtl/muxn_rr_if.sv
// Handshake bundle between N producers, the round-robin mux and one consumer.
// Ports: in_valid/in_data/in_ready per channel, out_valid/out_data/out_sel/out_ready
// toward the consumer, in_last per channel when MUXN_RR_LOCK_EN is defined.
interface muxn_rr_if #(
    parameter int W = 8,
    parameter int N = 4
);
    localparam int SW = $clog2(N);

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;
    logic           out_ready;
`ifdef MUXN_RR_LOCK_EN
    logic [N-1:0]   in_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
`endif
endinterface

// File: rtl/muxn_rr.sv
// N-channel W-bit round-robin mux with a registered one-beat output stage.
// Latency: one cycle from input transfer to out_valid; one beat per cycle sustained.
// Backpressure: in_ready is combinational from out_ready/in_valid; none while full and stalled.
// Ports: clk, rst (sync active-high), bus (muxn_rr_if.slave).
// Optional MUXN_RR_LOCK_EN: adds in_last and holds the grant on one channel until its last beat.
module muxn_rr #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic        clk,
    input  logic        rst,
    muxn_rr_if.slave    bus
);
    localparam int SW = $clog2(N);

    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_sel;
    logic [SW-1:0] r_ptr;
`ifdef MUXN_RR_LOCK_EN
    logic          r_lock;
`endif

    logic          w_load;
    logic          w_any;
    logic          w_xfer;
    logic [SW-1:0] w_grant;
    logic [SW-1:0] w_next;
    logic [W-1:0]  w_data;
    int            w_dist;
    int            w_best;

    assign w_load = !r_out_valid || bus.out_ready;

    // Arbitration: the valid channel with the smallest forward distance from r_ptr wins.
    always_comb begin
        w_grant = r_ptr;
        w_best  = N;
        w_dist  = 0;
        for (int i = 0; i < N; i++) begin
            w_dist = (i >= int'(r_ptr)) ? (i - int'(r_ptr)) : (i + N - int'(r_ptr));
            if (bus.in_valid[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_grant = SW'(i);
            end
        end
        w_any = (w_best < N);
`ifdef MUXN_RR_LOCK_EN
        // While locked, only the owning channel (the last one transferred) may be granted.
        if (r_lock) begin
            w_grant = r_out_sel;
            w_any   = bus.in_valid[r_out_sel];
        end
`endif
    end

    assign w_xfer = w_load && w_any && !rst;
    // Explicit wrap so that non-power-of-two N goes N-1 -> 0.
    assign w_next = (w_grant == SW'(N - 1)) ? '0 : (w_grant + SW'(1));

    always_comb begin
        w_data       = '0;
        bus.in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == SW'(i)) begin
                w_data          = bus.in_data[i*W +: W];
                bus.in_ready[i] = w_xfer;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
`ifdef MUXN_RR_LOCK_EN
            r_lock      <= 1'b0;
`endif
        end else if (w_load) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_data;
                r_out_sel   <= w_grant;
`ifdef MUXN_RR_LOCK_EN
                // ptr stays put while a packet is in flight; it moves on the last beat.
                if (bus.in_last[w_grant]) begin
                    r_lock <= 1'b0;
                    r_ptr  <= w_next;
                end else begin
                    r_lock <= 1'b1;
                end
`else
                r_ptr <= w_next;
`endif
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
endmodule

// File: doc/muxn_rr.md
# muxn_rr

Parametrised N-channel, W-bit multiplexer with round-robin arbitration, valid/ready handshakes on every channel and a registered output stage. It replaces fixed 2:1 select logic wherever several producers share one consumer. Selection is made by a fair arbiter rather than an external select line. The selected channel index travels with the data.

## Interface
- `W`, default 8: data width per channel, ≥1.
- `N`, default 4: channel count, ≥2.
- `SW` (localparam): `$clog2(N)`, width of the channel index.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  N  per-channel valid; bit i belongs to channel i.
- `in_data`  in  N*W  channel i occupies bits `[i*W +: W]`.
- `in_ready`  out  N  per-channel ready; at most one bit is set (one-hot or zero).
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  W  registered data.
- `out_sel`  out  SW  index of the channel that produced `out_data`.
- `out_ready`  in  1  consumer accepts the beat.
- `in_last`  in  N  end-of-packet flag per channel. Present only with `MUXN_RR_LOCK_EN`.

## Operation
- Two-state FSM, encoded by `out_valid`:
  - EMPTY (`out_valid`=0).
  - FULL (`out_valid`=1).
- `load = !out_valid || out_ready`.
- Rotating pointer `ptr` (SW bits), reset 0. Arbitration scans channels ptr, ptr+1, …, ptr+N−1 (mod N). The grant `g` is the first channel with `in_valid` high.
- `in_ready[g] = load && any(in_valid) && !rst`. All other bits of `in_ready` are 0. `in_ready` never depends on the channel's own `in_valid` except through arbitration.
- A transfer on channel i occurs when `in_valid[i] && in_ready[i]`. On a transfer at a clock edge:
  - `out_data` ← channel g data.
  - `out_sel` ← g.
  - `out_valid` ← 1.
  - `ptr` ← (g+1) mod N. Wrap applies when N is not a power of two: index N−1 is followed by 0.
- When `load` is high and no channel is valid: `out_valid` ← 0. `out_data` and `out_sel` hold their values.
- When FULL and `!out_ready`: all registers hold and `in_ready` is 0.
- Simultaneous consume and load (FULL, `out_ready`=1, some valid): the new beat replaces the old one in the same edge, with no bubble.
- Data integrity: the input channel must hold `in_data` stable while valid and not ready. The block does not check this.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0. `in_ready`=0 while `rst` is high.
- Reset during operation discards any held beat and clears the lock state. In the first cycle after reset, channel 0 has highest priority.
- Latency: one cycle from input transfer to `out_valid`.
- Throughput: one beat per cycle while `out_ready` stays high.
- `in_ready` is combinational from `out_ready` and `in_valid`. `out_*` are pure registers.
- Fairness: with all N channels continuously valid, each channel receives exactly one grant every N beats.

## Configuration
- `MUXN_RR_LOCK_EN` defined:
  - The `in_last` port exists.
  - After a transfer from channel g with `in_last[g]`=0, the arbiter locks to g. `in_ready` can then be asserted only for g, even if other channels are valid, and `ptr` does not advance.
  - The lock releases on the transfer where `in_last[g]`=1. At that point `ptr` ← (g+1) mod N.
  - Reset clears the lock.
- Undefined: the `in_last` port is absent and the block arbitrates on every beat.

## Test plan
- Reset and idle: hold `rst` 2 cycles with all inputs valid. Expect `in_ready`=0 and `out_valid`=0 throughout. First grant is channel 0 (N=4, W=8).
- Round robin: all four channels valid with data 0x10/0x21/0x32/0x43, `out_ready`=1. Expect `out_sel` sequence 0,1,2,3,0,… with matching data and one beat per cycle.
- Backpressure: FULL with data 0x21, `out_ready`=0 for 3 cycles. Expect `out_data` to hold 0x21 and `in_ready`=0. On release, the next beat follows with no gap.
- Sparse and wrap: only channels 3 and 1 valid, ptr=2. Grant order is 3 then 1; ptr wraps 3→0. N=3 variant: grant order 2,0,1.
- Lock (`MUXN_RR_LOCK_EN`): channel 1 sends 3 beats, `in_last` only on the third, while channel 2 is valid. Expect `out_sel`=1,1,1, then 2.
- Reset mid-stream: assert `rst` while FULL. The next cycle shows `out_valid`=0, and the first grant after reset is channel 0.
